// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: state set, sizing constants,
// address error check and byte-strobe merge.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES  = 4;
  localparam int MAX_LATENCY = 15;

  // Misaligned, or any address bit above the word-index field set (no wrap-around).
  function automatic logic addr_err(input logic [31:0] addr, input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Four-bit load/decrement countdown with a zero flag; paces the WAIT phase of the responder.
module dmem_wait_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_r;

  // Countdown register, saturating at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 4'd0);

endmodule

// File: rtl/dmem_responder.sv
// Handshaked, latency-bearing word responder in front of the data RAM.
// Optional byte-strobe writes are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]    state_r;
  logic          we_r;
  logic          err_r;
  logic [AW-1:0] idx_r;
  logic [31:0]   wdata_r;
  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic [31:0]   rsp_rdata_r;
  logic [31:0]   mem_r [DEPTH] = '{default: 32'd0};

  logic          accept_s;
  logic          cnt_zero_s;
  logic          enter_resp_s;
  logic          acc_we_s;
  logic          acc_err_s;
  logic [AW-1:0] acc_idx_s;
  logic [31:0]   acc_wdata_s;
  logic [31:0]   wr_word_s;

  assign accept_s = req_valid && req_ready;

  // With LATENCY==1 RESP is entered on the acceptance edge, so the live request is used there.
  assign acc_we_s    = (state_r == ST_IDLE) ? req_we                : we_r;
  assign acc_err_s   = (state_r == ST_IDLE) ? addr_err(req_addr, AW) : err_r;
  assign acc_idx_s   = (state_r == ST_IDLE) ? req_addr[AW+1:2]      : idx_r;
  assign acc_wdata_s = (state_r == ST_IDLE) ? req_wdata             : wdata_r;

  assign enter_resp_s = ((state_r == ST_IDLE) && accept_s && (LATENCY == 1)) ||
                        ((state_r == ST_WAIT) && cnt_zero_s);

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0] wstrb_r;
  logic [3:0] acc_wstrb_s;

  assign acc_wstrb_s = (state_r == ST_IDLE) ? req_wstrb : wstrb_r;
  assign wr_word_s   = strobe_merge(mem_r[acc_idx_s], acc_wdata_s, acc_wstrb_s);

  // Strobe latch alongside the rest of the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstrb_r <= 4'd0;
    end else if (accept_s) begin
      wstrb_r <= req_wstrb;
    end else begin
      wstrb_r <= wstrb_r;
    end
  end
`else
  assign wr_word_s = acc_wdata_s;
`endif

  dmem_wait_counter u_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept_s),
    .load_value (4'(LATENCY - 1)),
    .dec        (state_r == ST_WAIT),
    .zero       (cnt_zero_s)
  );

  // Request FSM and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      err_r       <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r    <= req_we;
            err_r   <= addr_err(req_addr, AW);
            idx_r   <= req_addr[AW+1:2];
            wdata_r <= req_wdata;
            state_r <= (LATENCY > 1) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (cnt_zero_s) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (enter_resp_s) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= acc_err_s;
        rsp_rdata_r <= (!acc_err_s && !acc_we_s) ? mem_r[acc_idx_s] : 32'd0;
      end
    end
  end

  // Backing store write; contents survive reset, and an aborted write never lands.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp_s && acc_we_s && !acc_err_s) begin
      mem_r[acc_idx_s] <= wr_word_s;
    end
  end

  assign req_ready = (state_r == ST_IDLE) && !reset;
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
